cnn_seq_ctrl: RTL and testbench
===============================

# cnn_seq_ctrl

Parametrised layer sequencer for the BNN inference datapath. It drives a bank of CH convolution engines through one conv1 pass and ITER conv2 passes, then one FC pass, and finally an argmax over NCLS class scores.
- Conv1 results are streamed to an external feature-map buffer.
- Conv2 partial sums are accumulated internally across passes, and the FC engine reads them.
- It sits between the input loader and the conv/FC engine banks, replacing the fixed 6-channel, 10-class controller.

## Interface
Parameters:
- CH, 6, number of parallel conv engines/channels
- DW, 32, signed data width
- FMAP1, 144, conv1 output words per channel per pass
- FMAP2, 16, conv2 output words per channel per pass
- ITER, 13, conv2 passes accumulated before FC
- NCLS, 10, number of classes

Ports (AW1 = clog2(FMAP1), AW2 = clog2(FMAP2)):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin inference; ignored unless IDLE
- eng_start  out  1  one-cycle pulse launching a conv pass
- eng_stage  out  1  0 = conv1, 1 = conv2
- eng_ovalid  in  CH  per-engine output valid
- eng_dout  in  CH*DW  per-engine result, channel c at [c*DW +: DW]
- eng_done  in  CH  per-engine pass done (level, held until next eng_start)
- buf_we  out  1  conv1 result write strobe
- buf_waddr  out  AW1  conv1 write address
- buf_wdata  out  CH*DW  conv1 results, registered copy of eng_dout
- fc_start  out  1  one-cycle pulse launching FC
- acc_raddr  in  AW2  FC read address into accumulator
- acc_rdata  out  CH*DW  combinational read of acc[*][acc_raddr]
- fc_ovalid  in  1  FC scores valid (one-cycle)
- fc_dout  in  NCLS*DW  signed class scores
- classes  out  NCLS  one-hot argmax, held until next start
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any state but IDLE
- err  out  1  sticky protocol error, cleared by start

## Operation
- States: IDLE, C1, C2, FC_WAIT, CMP, FIN.
- IDLE → C1 on start.
  - Clears err and the counters.
  - Pulses eng_start with eng_stage=0.
- C1 (conv1 capture):
  - Capture occurs only when eng_ovalid is all-ones.
  - On capture: buf_we=1, buf_waddr=wcnt, buf_wdata=eng_dout, then wcnt+1. wcnt saturates at FMAP1.
  - Partial eng_ovalid (non-zero, not all-ones) sets err and writes nothing.
- C1 → C2 when eng_done is all-ones.
  - If wcnt≠FMAP1 at that point, err is set.
  - Pulses eng_start with eng_stage=1, pass=0, wcnt=0.
- C2 (conv2 capture):
  - Each all-ones eng_ovalid updates acc[c][wcnt] for every channel c.
  - Pass 0: acc = eng_dout. Later passes: acc += eng_dout.
  - wcnt saturates at FMAP2; the same partial-valid and count-mismatch err rules apply.
- C2 on eng_done all-ones:
  - If pass<ITER-1: pass+1, wcnt=0, eng_start re-pulsed, stay in C2.
  - Otherwise → FC_WAIT with a fc_start pulse.
- FC_WAIT:
  - On fc_ovalid, latches fc_dout into score regs → CMP.
  - acc_rdata stays valid in every state.
- CMP (sequential argmax):
  - One score per cycle, index 0..NCLS-1, signed compare.
  - Strict greater-than, so ties resolve to the lowest index.
  - After index NCLS-1: classes = one-hot(best) → FIN.
- FIN: done=1 for one cycle → IDLE.
- start while busy is ignored. eng_* inputs in IDLE are ignored.
- Accumulator width is DW, two's-complement wrap (see Configuration).

## Timing
- Reset values: eng_start=0, eng_stage=0, buf_we=0, buf_waddr=0, buf_wdata=0, fc_start=0, classes=0, done=0, busy=0, err=0. Counters and state are reset to IDLE/0. acc and score regs are not reset.
- start sampled at cycle t → eng_start high at t+1, busy high at t+1.
- buf_we/buf_waddr/buf_wdata are registered: high the cycle after the ovalid capture.
- Accumulator write lands one cycle after capture.
- eng_done all-ones sampled at t → next eng_start (or fc_start) at t+1.
- CMP takes NCLS cycles. classes updates in the same cycle that done pulses, i.e. NCLS+1 cycles after fc_ovalid.
- ovalid all-ones and eng_done all-ones in the same cycle: the capture is performed first and counted in the count check.
- rstn asserted mid-operation: immediate return to IDLE, outputs to reset values, no done pulse.

## Configuration
- CNN_SEQ_SAT_EN defined: conv2 accumulation saturates to [-2^(DW-1), 2^(DW-1)-1], and any saturation event sets err.
- Undefined: plain DW-bit wrap; err is unaffected by overflow.

## Test plan
- Defaults, start, engines return 144 all-ones valids then done, then 13×16 valids all with value 1, then fc_dout with class 7 = 100 and others = 5 → buf_we asserted 144 times with addresses 0..143, acc_rdata all channels = 13, classes=0x080, done one pulse, err=0.
- Tie: fc scores 3 and 8 both 50, others -1 → classes=0x008.
- eng_ovalid=6'b011111 once during C1 → err=1 and no buf_we that cycle. The run still completes with a done pulse.
- eng_done after only 100 conv1 captures → err=1 and C2 entered.
- CNN_SEQ_SAT_EN with eng_dout=0x7FFFFFFF on every pass → acc holds 0x7FFFFFFF and err=1. Without the macro, the value wraps and err=0.
- rstn pulsed during C2 pass 5 → all outputs reset. A fresh start then runs the full sequence cleanly.

Source files
------------

// File: rtl/cnn_seq_ctrl.sv
// Layer sequencer for the BNN datapath: conv1 -> ITER accumulated conv2 passes -> FC -> argmax.
// Build option: define CNN_SEQ_SAT_EN for saturating conv2 accumulation (saturation sets err_o).
module cnn_seq_ctrl #(
  parameter int unsigned CH    = 6,
  parameter int unsigned DW    = 32,
  parameter int unsigned FMAP1 = 144,
  parameter int unsigned FMAP2 = 16,
  parameter int unsigned ITER  = 13,
  parameter int unsigned NCLS  = 10,
  localparam int unsigned AW1  = $clog2(FMAP1),
  localparam int unsigned AW2  = $clog2(FMAP2)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  output logic                 eng_start_o,
  output logic                 eng_stage_o,
  input  logic [CH-1:0]        eng_ovalid_i,
  input  logic [CH*DW-1:0]     eng_dout_i,
  input  logic [CH-1:0]        eng_done_i,
  output logic                 buf_we_o,
  output logic [AW1-1:0]       buf_waddr_o,
  output logic [CH*DW-1:0]     buf_wdata_o,
  output logic                 fc_start_o,
  input  logic [AW2-1:0]       acc_raddr_i,
  output logic [CH*DW-1:0]     acc_rdata_o,
  input  logic                 fc_ovalid_i,
  input  logic [NCLS*DW-1:0]   fc_dout_i,
  output logic [NCLS-1:0]      classes_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned FMAX = (FMAP1 > FMAP2) ? FMAP1 : FMAP2;
  localparam int unsigned CW   = $clog2(FMAX + 1);
  localparam int unsigned PW   = $clog2(ITER + 1);
  localparam int unsigned IW   = (NCLS > 1) ? $clog2(NCLS) : 1;

  typedef enum logic [2:0] {StIdle, StC1, StC2, StFcWait, StCmp, StFin} state_e;

  state_e               state_q;
  logic [CW-1:0]        wcnt_q;
  logic [PW-1:0]        pass_q;
  logic [IW-1:0]        cmp_idx_q;
  logic [IW-1:0]        best_idx_q;
  logic signed [DW-1:0] best_val_q;
  logic                 eng_start_q;
  logic                 eng_stage_q;
  logic                 buf_we_q;
  logic [AW1-1:0]       buf_waddr_q;
  logic [CH*DW-1:0]     buf_wdata_q;
  logic                 fc_start_q;
  logic [NCLS-1:0]      classes_q;
  logic                 done_q;
  logic                 err_q;
  logic                 cap_q;
  logic [AW2-1:0]       cap_addr_q;
  logic [CH*DW-1:0]     cap_data_q;
  logic                 cap_first_q;

  logic [DW-1:0]        acc_q [CH][FMAP2];
  logic signed [DW-1:0] score_q [NCLS];

  logic                 ovalid_full;
  logic                 ovalid_part;
  logic                 done_full;
  logic                 cap_ok;
  logic [CW-1:0]        wcnt_lim;
  logic [CW-1:0]        wcnt_eff;
  logic signed [DW-1:0] cur_score;
  logic                 cand_better;
  logic [IW-1:0]        best_nxt;
  logic signed [DW-1:0] best_val_nxt;
  logic [DW-1:0]        acc_old  [CH];
  logic [DW-1:0]        add_dat  [CH];
  logic [DW-1:0]        acc_wval [CH];

  // eng_done is a level held until the engines see eng_start, so ignore it on the pulse cycle.
  always_comb begin
    ovalid_full = &eng_ovalid_i;
    ovalid_part = (|eng_ovalid_i) && !ovalid_full;
    done_full   = (&eng_done_i) && !eng_start_q;
    wcnt_lim    = (state_q == StC2) ? CW'(FMAP2) : CW'(FMAP1);
    cap_ok      = ovalid_full && (wcnt_q != wcnt_lim);
    wcnt_eff    = wcnt_q + CW'(cap_ok);
  end

  always_comb begin
    cur_score    = score_q[cmp_idx_q];
    cand_better  = (cmp_idx_q == '0) || (cur_score > best_val_q);
    best_nxt     = cand_better ? cmp_idx_q : best_idx_q;
    best_val_nxt = cand_better ? cur_score : best_val_q;
  end

  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      acc_old[c] = acc_q[c][cap_addr_q];
      add_dat[c] = cap_data_q[c*DW +: DW];
    end
  end

`ifdef CNN_SEQ_SAT_EN
  logic [DW:0]   sum_ext [CH];
  logic [CH-1:0] sat_ch;
  logic          sat_evt;

  always_comb begin
    sat_ch = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      sum_ext[c]  = {acc_old[c][DW-1], acc_old[c]} + {add_dat[c][DW-1], add_dat[c]};
      acc_wval[c] = sum_ext[c][DW-1:0];
      if (cap_first_q) begin
        acc_wval[c] = add_dat[c];
      end else if (sum_ext[c][DW] != sum_ext[c][DW-1]) begin
        sat_ch[c]   = 1'b1;
        acc_wval[c] = sum_ext[c][DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
  end

  assign sat_evt = cap_q && (|sat_ch);
`else
  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      acc_wval[c] = cap_first_q ? add_dat[c] : acc_old[c] + add_dat[c];
    end
  end
`endif

  always_comb begin
    acc_rdata_o = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      acc_rdata_o[c*DW +: DW] = acc_q[c][acc_raddr_i];
    end
  end

  // Datapath storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (cap_q) begin
      for (int unsigned c = 0; c < CH; c++) begin
        acc_q[c][cap_addr_q] <= acc_wval[c];
      end
    end
    if (state_q == StFcWait && fc_ovalid_i) begin
      for (int unsigned k = 0; k < NCLS; k++) begin
        score_q[k] <= fc_dout_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      pass_q      <= '0;
      cmp_idx_q   <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      eng_start_q <= 1'b0;
      eng_stage_q <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
      fc_start_q  <= 1'b0;
      classes_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cap_q       <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      cap_first_q <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      buf_we_q    <= 1'b0;
      fc_start_q  <= 1'b0;
      done_q      <= 1'b0;
      cap_q       <= 1'b0;
`ifdef CNN_SEQ_SAT_EN
      if (sat_evt) err_q <= 1'b1;
`endif
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StC1;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            pass_q      <= '0;
            classes_q   <= '0;
            eng_start_q <= 1'b1;
            eng_stage_q <= 1'b0;
          end
        end
        StC1: begin
          if (cap_ok) begin
            buf_we_q    <= 1'b1;
            buf_waddr_q <= wcnt_q[AW1-1:0];
            buf_wdata_q <= eng_dout_i;
            wcnt_q      <= wcnt_q + CW'(1);
          end else if (ovalid_part) begin
            err_q <= 1'b1;
          end
          if (done_full) begin
            if (wcnt_eff != CW'(FMAP1)) err_q <= 1'b1;
            state_q     <= StC2;
            wcnt_q      <= '0;
            pass_q      <= '0;
            eng_start_q <= 1'b1;
            eng_stage_q <= 1'b1;
          end
        end
        StC2: begin
          if (cap_ok) begin
            cap_q       <= 1'b1;
            cap_addr_q  <= wcnt_q[AW2-1:0];
            cap_data_q  <= eng_dout_i;
            cap_first_q <= (pass_q == '0);
            wcnt_q      <= wcnt_q + CW'(1);
          end else if (ovalid_part) begin
            err_q <= 1'b1;
          end
          if (done_full) begin
            if (wcnt_eff != CW'(FMAP2)) err_q <= 1'b1;
            wcnt_q <= '0;
            if (pass_q < PW'(ITER - 1)) begin
              pass_q      <= pass_q + PW'(1);
              eng_start_q <= 1'b1;
            end else begin
              fc_start_q <= 1'b1;
              state_q    <= StFcWait;
            end
          end
        end
        StFcWait: begin
          if (fc_ovalid_i) begin
            state_q   <= StCmp;
            cmp_idx_q <= '0;
          end
        end
        StCmp: begin
          best_idx_q <= best_nxt;
          best_val_q <= best_val_nxt;
          cmp_idx_q  <= cmp_idx_q + IW'(1);
          if (cmp_idx_q == IW'(NCLS - 1)) begin
            classes_q <= NCLS'(1) << best_nxt;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng_start_o = eng_start_q;
  assign eng_stage_o = eng_stage_q;
  assign buf_we_o    = buf_we_q;
  assign buf_waddr_o = buf_waddr_q;
  assign buf_wdata_o = buf_wdata_q;
  assign fc_start_o  = fc_start_q;
  assign classes_o   = classes_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Scoreboard bench for cnn_seq_ctrl: directed inference runs, monitor checks buf writes and done.
module tb_cnn_seq_ctrl;
  localparam int CH    = 6;
  localparam int DW    = 32;
  localparam int FMAP1 = 144;
  localparam int FMAP2 = 16;
  localparam int ITER  = 13;
  localparam int NCLS  = 10;
  localparam int AW1   = $clog2(FMAP1);
  localparam int AW2   = $clog2(FMAP2);

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start_i = 1'b0;
  logic               eng_start_o, eng_stage_o;
  logic [CH-1:0]      eng_ovalid_i = '0;
  logic [CH*DW-1:0]   eng_dout_i = '0;
  logic [CH-1:0]      eng_done_i = '0;
  logic               buf_we_o;
  logic [AW1-1:0]     buf_waddr_o;
  logic [CH*DW-1:0]   buf_wdata_o;
  logic               fc_start_o;
  logic [AW2-1:0]     acc_raddr_i = '0;
  logic [CH*DW-1:0]   acc_rdata_o;
  logic               fc_ovalid_i = 1'b0;
  logic [NCLS*DW-1:0] fc_dout_i = '0;
  logic [NCLS-1:0]    classes_o;
  logic               done_o, busy_o, err_o;

  cnn_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .eng_start_o(eng_start_o), .eng_stage_o(eng_stage_o),
    .eng_ovalid_i(eng_ovalid_i), .eng_dout_i(eng_dout_i), .eng_done_i(eng_done_i),
    .buf_we_o(buf_we_o), .buf_waddr_o(buf_waddr_o), .buf_wdata_o(buf_wdata_o),
    .fc_start_o(fc_start_o), .acc_raddr_i(acc_raddr_i), .acc_rdata_o(acc_rdata_o),
    .fc_ovalid_i(fc_ovalid_i), .fc_dout_i(fc_dout_i), .classes_o(classes_o),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW1-1:0]   addr;
    logic [CH*DW-1:0] data;
  } buf_exp_t;
  typedef struct packed {
    logic [NCLS-1:0] classes;
    logic            err;
  } done_exp_t;

  buf_exp_t  buf_exp [$];
  done_exp_t done_exp [$];
  buf_exp_t  mon_be;
  done_exp_t mon_de;
  int n_vec = 0;
  int n_bad = 0;
  int n_buf = 0;

  // Run configuration
  int                   c1_caps, part_at, c2_kind, rst_pass;
  logic signed [DW-1:0] scores [NCLS];
  logic [NCLS-1:0]      exp_cls;
  logic                 exp_err;

  task automatic check(input string name, input logic [CH*DW-1:0] act,
                       input logic [CH*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (buf_we_o) begin
        n_buf++;
        if (buf_exp.size() == 0) begin
          check("buf_we unexpected", buf_we_o, 1'b0);
        end else begin
          mon_be = buf_exp.pop_front();
          check("buf_waddr", buf_waddr_o, mon_be.addr);
          check("buf_wdata", buf_wdata_o, mon_be.data);
        end
      end
      if (done_o) begin
        if (done_exp.size() == 0) begin
          check("done unexpected", done_o, 1'b0);
        end else begin
          mon_de = done_exp.pop_front();
          check("classes at done", classes_o, mon_de.classes);
          check("err at done", err_o, mon_de.err);
        end
      end
    end
  end

  function automatic logic [CH*DW-1:0] c1_word(input int i);
    logic [CH*DW-1:0] w;
    for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(i * 256 + c + 1);
    return w;
  endfunction

  function automatic logic [CH*DW-1:0] c2_word(input int p, input int a);
    logic [CH*DW-1:0] w;
    for (int c = 0; c < CH; c++) begin
      case (c2_kind)
        0:       w[c*DW +: DW] = DW'(c - a + p);
        1:       w[c*DW +: DW] = DW'(1);
        default: w[c*DW +: DW] = 32'h7FFF_FFFF;
      endcase
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] acc_exp(input int c, input int a);
    logic [63:0] t;
    case (c2_kind)
      0: return DW'(ITER * (c - a) + ITER * (ITER - 1) / 2);
      1: return DW'(ITER);
      default: begin
`ifdef CNN_SEQ_SAT_EN
        return 32'h7FFF_FFFF;
`else
        t = 64'(ITER) * 64'h7FFF_FFFF;
        return t[DW-1:0];
`endif
      end
    endcase
  endfunction

  task automatic wait_sig(input int which, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if ((which == 0 && eng_start_o) || (which == 2 && done_o)) begin
        cyc = k;
        return;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL timeout waiting on event %0d: got none, required within 64 cycles", which);
  endtask

  task automatic cfg(input int c1, input int part, input int kind, input int rstp, input bit tie);
    c1_caps  = c1;
    part_at  = part;
    c2_kind  = kind;
    rst_pass = rstp;
    for (int k = 0; k < NCLS; k++) scores[k] = tie ? -1 : 5;
    if (tie) begin
      scores[3] = 50;
      scores[8] = 50;
      exp_cls   = NCLS'(1) << 3;
    end else begin
      scores[7] = 100;
      exp_cls   = NCLS'(1) << 7;
    end
    exp_err = (part >= 0) || (c1 != FMAP1);
`ifdef CNN_SEQ_SAT_EN
    if (kind == 2) exp_err = 1'b1;
`endif
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " eng_start"}, eng_start_o, 1'b0);
    check({tag, " eng_stage"}, eng_stage_o, 1'b0);
    check({tag, " buf_we"}, buf_we_o, 1'b0);
    check({tag, " buf_waddr"}, buf_waddr_o, '0);
    check({tag, " buf_wdata"}, buf_wdata_o, '0);
    check({tag, " fc_start"}, fc_start_o, 1'b0);
    check({tag, " classes"}, classes_o, '0);
    check({tag, " done"}, done_o, 1'b0);
    check({tag, " busy"}, busy_o, 1'b0);
    check({tag, " err"}, err_o, 1'b0);
  endtask

  task automatic run_inf();
    int cyc;
    n_buf = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("eng_start after start", eng_start_o, 1'b1);
    check("busy after start", busy_o, 1'b1);
    check("eng_stage conv1", eng_stage_o, 1'b0);
    eng_done_i = '0;
    for (int i = 0; i < c1_caps; i++) begin
      if (i == part_at) begin
        eng_ovalid_i = {1'b0, {(CH-1){1'b1}}};
        eng_dout_i   = '1;
        tick();
      end
      eng_ovalid_i = '1;
      eng_dout_i   = c1_word(i);
      buf_exp.push_back('{addr: AW1'(i), data: c1_word(i)});
      tick();
      if (i % 5 == 0) begin
        eng_ovalid_i = '0;
        tick();
      end
    end
    eng_ovalid_i = '0;
    eng_done_i   = '1;
    wait_sig(0, cyc);
    check("conv2 start latency", cyc, 1);
    check("eng_stage conv2", eng_stage_o, 1'b1);
    eng_done_i = '0;
    check("buf_we count", n_buf, c1_caps);
    for (int p = 0; p < ITER; p++) begin
      for (int a = 0; a < FMAP2; a++) begin
        eng_ovalid_i = '1;
        eng_dout_i   = c2_word(p, a);
        if (a == FMAP2 - 1) eng_done_i = '1;
        tick();
        if (p == rst_pass && a == 5) begin
          rstn = 1'b0;
          #1;
          check_reset_outs("mid-run reset");
          eng_ovalid_i = '0;
          eng_done_i   = '0;
          tick();
          tick();
          rstn = 1'b1;
          buf_exp.delete();
          done_exp.delete();
          tick();
          return;
        end
      end
      eng_ovalid_i = '0;
      if (p < ITER - 1) check("conv2 pass restart", eng_start_o, 1'b1);
      else check("fc_start after last pass", fc_start_o, 1'b1);
      eng_done_i = '0;
    end
    tick();
    tick();
    for (int k = 0; k < NCLS; k++) fc_dout_i[k*DW +: DW] = scores[k];
    fc_ovalid_i = 1'b1;
    done_exp.push_back('{classes: exp_cls, err: exp_err});
    tick();
    fc_ovalid_i = 1'b0;
    wait_sig(2, cyc);
    check("done latency after fc_ovalid", cyc + 1, NCLS + 1);
    tick();
    check("busy after done", busy_o, 1'b0);
    check("done is one pulse", done_o, 1'b0);
    for (int a = 0; a < FMAP2; a += FMAP2 - 1) begin
      acc_raddr_i = AW2'(a);
      #1;
      for (int c = 0; c < CH; c++) check("acc_rdata", acc_rdata_o[c*DW +: DW], acc_exp(c, a));
    end
    check("scoreboard drained", buf_exp.size() + done_exp.size(), 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outs("reset");
    rstn = 1'b1;
    tick();
    cfg(FMAP1, -1, 1, -1, 1'b0);  // baseline: all-ones conv2 data, class 7 wins
    run_inf();
    cfg(FMAP1, 50, 0, -1, 1'b0);  // partial ovalid in conv1
    run_inf();
    cfg(FMAP1, -1, 0, -1, 1'b1);  // tie between classes 3 and 8
    run_inf();
    cfg(100, -1, 0, -1, 1'b0);    // early conv1 done
    run_inf();
    cfg(FMAP1, -1, 2, -1, 1'b0);  // accumulator overflow
    run_inf();
    cfg(FMAP1, -1, 0, 5, 1'b0);   // reset during conv2 pass 5
    run_inf();
    cfg(FMAP1, -1, 1, -1, 1'b0);  // clean run after reset
    run_inf();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
